apu_frame_sequencer: RTL

APU_FRAME_SEQUENCER -- requirements
Module: apu_frame_sequencer

---
 rtl/apu_pkg.sv | 7 +
 rtl/apu_div_fall_detect.sv | 15 +
 rtl/apu_frame_sequencer.sv | 68 ++++++
 3 files changed

// File: rtl/apu_pkg.sv
// apu_pkg: shared APU frame-sequencer constants; step masks are indexed by frame step.
package apu_pkg;
  localparam int FS_STEP_W = 3;
  localparam logic [7:0] FS_LEN_MASK = 8'b0101_0101;
  localparam logic [7:0] FS_SWEEP_MASK = 8'b0100_0100;
  localparam logic [7:0] FS_ENV_MASK = 8'b1000_0000;
endpackage

// File: rtl/apu_div_fall_detect.sv
// apu_div_fall_detect: registers the selected DIV bit and flags its falling edge.
// Ports: clk, rst (sync, active high), sel_bit (selected DIV bit), reload (source switched), tick.
module apu_div_fall_detect (
  input  logic clk,
  input  logic rst,
  input  logic sel_bit,
  input  logic reload,
  output logic tick
);
  logic div_q;
  always_ff @(posedge clk)
    div_q <= rst ? 1'b0 : sel_bit;
  // a reload means the source bit changed, so the stale div_q must not create an edge
  assign tick = div_q & ~sel_bit & ~reload;
endmodule

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: DIV-driven 8-step frame sequencer emitting length, sweep and envelope clocks.
// Ports: apuv_4mhz clock, apu_reset (sync, active high), apu_on, div_bit4 -> len_clk, sweep_clk, env_clk, frame_step.
// APU_FS_DOUBLE_SPEED_EN adds div_bit5 and double_speed to select DIV bit 5 in double-speed mode.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int STEP_W = FS_STEP_W
) (
  input  logic              apuv_4mhz,
  input  logic              apu_reset,
  input  logic              apu_on,
  input  logic              div_bit4,
`ifdef APU_FS_DOUBLE_SPEED_EN
  input  logic              div_bit5,
  input  logic              double_speed,
`endif
  output logic              len_clk,
  output logic              sweep_clk,
  output logic              env_clk,
  output logic [STEP_W-1:0] frame_step
);
  logic sel_bit, reload, tick, on_q, skip_pending;
`ifdef APU_FS_DOUBLE_SPEED_EN
  logic ds_q;
  always_ff @(posedge apuv_4mhz)
    ds_q <= apu_reset ? 1'b0 : double_speed;
  assign sel_bit = double_speed ? div_bit5 : div_bit4;
  assign reload = double_speed ^ ds_q;
`else
  assign sel_bit = div_bit4;
  assign reload = 1'b0;
`endif
  apu_div_fall_detect u_fall (
    .clk(apuv_4mhz),
    .rst(apu_reset),
    .sel_bit(sel_bit),
    .reload(reload),
    .tick(tick)
  );
  always_ff @(posedge apuv_4mhz) begin
    len_clk <= 1'b0;
    sweep_clk <= 1'b0;
    env_clk <= 1'b0;
    if (apu_reset) begin
      on_q <= 1'b0;
      skip_pending <= 1'b0;
      frame_step <= '0;
    end else begin
      on_q <= apu_on;
      if (!apu_on) begin
        frame_step <= '0;
        skip_pending <= 1'b0;
      end else if (!on_q) begin
        // power-up while DIV bit is high: its first fall is swallowed
        skip_pending <= sel_bit;
      end else if (tick) begin
        if (skip_pending) begin
          skip_pending <= 1'b0;
        end else begin
          len_clk <= FS_LEN_MASK[frame_step];
          sweep_clk <= FS_SWEEP_MASK[frame_step];
          env_clk <= FS_ENV_MASK[frame_step];
          frame_step <= frame_step + 1'b1;
        end
      end
    end
  end
endmodule
